frame_loader: RTL

FRAME_LOADER -- requirements
Module: frame_loader

---
 rtl/frame_loader_pkg.sv | 15 +
 rtl/frame_loader_ctrl.sv | 97 +++++++++
 rtl/frame_loader.sv | 72 +++++++
 3 files changed

// File: rtl/frame_loader_pkg.sv
// Shared constants and types for the double-buffered frame loader.
package frame_loader_pkg;

  localparam int NPIX = 784;
  localparam int PW   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_t;

  typedef logic [PW-1:0] pixel_t;

endpackage

// File: rtl/frame_loader_ctrl.sv
// Loader FSM: tracks the write index into the back buffer, pixel handshake
// and the swap strobe that copies the back buffer to the display.
module frame_loader_ctrl #(
  parameter int NPIX = 784
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    pix_valid,
  input  logic                    pix_sof,
  input  logic                    vsync_tick,
  output logic                    pix_ready,
  output logic                    wr_en,
  output logic [$clog2(NPIX)-1:0] wr_addr,
  output logic                    sof_restart,
  output logic                    swap
);
  import frame_loader_pkg::*;

  localparam int IW = $clog2(NPIX);
  localparam logic [IW-1:0] LAST_IDX = IW'(NPIX - 1);

  state_t          r_state;
  state_t          w_next_state;
  logic [IW-1:0]   r_wr_idx;
  logic [IW-1:0]   w_next_idx;
  logic            r_pix_ready;
  logic            w_accept;

  // Next-state, write-port and strobe decode.
  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_wr_idx;
    wr_en        = 1'b0;
    wr_addr      = r_wr_idx;
    sof_restart  = 1'b0;
    swap         = 1'b0;
    w_accept     = pix_valid & r_pix_ready;
    case (r_state)
      IDLE: begin
        if (w_accept && pix_sof) begin
          wr_en        = 1'b1;
          wr_addr      = '0;
          w_next_idx   = IW'(1);
          w_next_state = FILL;
        end else begin
          w_next_state = IDLE;
        end
      end
      FILL: begin
        if (w_accept && pix_sof) begin
          // a fresh SOF restarts the frame from pixel 0
          wr_en       = 1'b1;
          wr_addr     = '0;
          w_next_idx  = IW'(1);
          sof_restart = 1'b1;
        end else if (w_accept && (r_wr_idx == LAST_IDX)) begin
          wr_en        = 1'b1;
          w_next_idx   = '0;
          w_next_state = FULL;
        end else if (w_accept) begin
          wr_en      = 1'b1;
          w_next_idx = r_wr_idx + IW'(1);
        end else begin
          w_next_state = FILL;
        end
      end
      FULL: begin
        if (vsync_tick) begin
          swap         = 1'b1;
          w_next_state = IDLE;
        end else begin
          w_next_state = FULL;
        end
      end
      default: begin
        w_next_state = IDLE;
        w_next_idx   = '0;
      end
    endcase
  end

  // State, index and registered ready (ready mirrors "not FULL").
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_wr_idx    <= '0;
      r_pix_ready <= 1'b1;
    end else begin
      r_state     <= w_next_state;
      r_wr_idx    <= w_next_idx;
      r_pix_ready <= (w_next_state != FULL);
    end
  end

  assign pix_ready = r_pix_ready;

endmodule

// File: rtl/frame_loader.sv
// Double-buffered frame loader: pixels fill a back buffer, and the whole
// frame is copied to the displayed image on a vsync tick once complete.
module frame_loader #(
  parameter int NPIX = 784,
  parameter int PW   = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [PW-1:0]            pix_in,
  input  logic                     pix_valid,
  input  logic                     pix_sof,
  output logic                     pix_ready,
  input  logic                     vsync_tick,
  output logic [NPIX-1:0][PW-1:0]  image,
  output logic [15:0]              frame_count,
  output logic                     sof_err
);
  import frame_loader_pkg::*;

  logic [NPIX-1:0][PW-1:0]  r_back;
  logic [NPIX-1:0][PW-1:0]  r_image;
  logic [15:0]              r_frame_count;
  logic                     r_sof_err;
  logic                     w_wr_en;
  logic [$clog2(NPIX)-1:0]  w_wr_addr;
  logic                     w_sof_restart;
  logic                     w_swap;

  frame_loader_ctrl #(
    .NPIX (NPIX)
  ) u_ctrl (
    .clock       (clock),
    .reset_n     (reset_n),
    .pix_valid   (pix_valid),
    .pix_sof     (pix_sof),
    .vsync_tick  (vsync_tick),
    .pix_ready   (pix_ready),
    .wr_en       (w_wr_en),
    .wr_addr     (w_wr_addr),
    .sof_restart (w_sof_restart),
    .swap        (w_swap)
  );

  // Back buffer write port; contents after reset are irrelevant.
  always_ff @(posedge clock) begin
    if (w_wr_en) begin
      r_back[w_wr_addr] <= pix_in;
    end
  end

  // Front buffer, swap counter and sticky restart flag.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_image       <= '0;
      r_frame_count <= 16'd0;
      r_sof_err     <= 1'b0;
    end else begin
      if (w_swap) begin
        r_image       <= r_back;
        r_frame_count <= r_frame_count + 16'd1;
      end
      if (w_sof_restart) begin
        r_sof_err <= 1'b1;
      end
    end
  end

  assign image       = r_image;
  assign frame_count = r_frame_count;
  assign sof_err     = r_sof_err;

endmodule
